// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Holds the scan state encoding and the row/column to hex key map.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } scan_state_t;

   function automatic logic [3:0] keymap(
      input logic [1:0] row,
      input logic [1:0] col
   );
      logic [3:0] k;
      k = 4'h0;
      unique case ({row, col})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = 4'hA;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = 4'hE;
         4'hD: k = 4'h0;
         4'hE: k = 4'hF;
         4'hF: k = 4'hD;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row returns.
// Resets to all-ones so an idle (pulled-up) keypad is seen during reset.
module row_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column multiplexing, debounce,
// single-cycle key events and a two-deep digit history.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_EXP   = 14,
   parameter int DEBOUNCE_TICKS = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS);

   logic [SCAN_DIV_EXP-1:0] div;
   logic                    tick;
   logic [3:0]              rows_s;

   scan_state_t state, state_nx;
   logic [1:0]    col, col_nx;
   logic [1:0]    row_q, row_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic [3:0]    code_nx, new_nx, old_nx;
   logic          kv_nx;

   logic          single_low;
   logic [1:0]    low_idx;
   logic          row_hi;
   logic          only_row;
   logic [3:0]    map_val;

   row_sync #(.W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row_n),
      .q     (rows_s)
   );

   assign tick     = &div;
   assign row_hi   = rows_s[row_q];
   assign only_row = (rows_s == ~(4'b0001 << row_q));
   assign map_val  = keymap(row_q, col);
   // Saturate so a long stable period can never wrap the count
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   always_comb begin
      single_low = 1'b1;
      low_idx    = 2'd0;
      unique case (rows_s)
         4'b1110: low_idx = 2'd0;
         4'b1101: low_idx = 2'd1;
         4'b1011: low_idx = 2'd2;
         4'b0111: low_idx = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row_q;
      cnt_nx   = cnt;
      code_nx  = key_code;
      new_nx   = digit_new;
      old_nx   = digit_old;
      kv_nx    = 1'b0;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (single_low) begin
                  row_nx   = low_idx;
                  cnt_nx   = '0;
                  state_nx = DEBOUNCE;
               end else begin
                  col_nx = col + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (only_row) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_nx = HELD;
                     kv_nx    = 1'b1;
                     code_nx  = map_val;
                     old_nx   = digit_new;
                     new_nx   = map_val;
                  end
               end else begin
                  cnt_nx   = '0;
                  col_nx   = col + 2'd1;
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (row_hi) begin
                  cnt_nx   = '0;
                  state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (row_hi) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     cnt_nx   = '0;
                     col_nx   = col + 2'd1;
                     state_nx = SCAN;
                  end
               end else begin
                  cnt_nx   = '0;
                  state_nx = HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div       <= '0;
         state     <= SCAN;
         col       <= 2'd0;
         row_q     <= 2'd0;
         cnt       <= '0;
         col_n     <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         digit_new <= 4'h0;
         digit_old <= 4'h0;
      end else begin
         div       <= div + SCAN_DIV_EXP'(1);
         state     <= state_nx;
         col       <= col_nx;
         row_q     <= row_nx;
         cnt       <= cnt_nx;
         col_n     <= ~(4'b0001 << col_nx);
         key_code  <= code_nx;
         key_valid <= kv_nx;
         digit_new <= new_nx;
         digit_old <= old_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad matrix model.
// Runs with a 4-cycle column dwell and a 3-tick debounce.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   logic [15:0] pressed = '0;
   logic        force_en = 1'b0;
   logic [3:0]  force_rows = 4'hF;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int long_pulses = 0;
   logic kv_prev = 1'b0;

   keypad_scanner #(
      .SCAN_DIV_EXP   (2),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .digit_new (digit_new),
      .digit_old (digit_old)
   );

   always #5 clk = ~clk;

   // Key (r,c) closed shorts row r to column c while that column is driven low
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_n[c])
               row_n[r] = 1'b0;
      if (force_en)
         row_n = force_rows;
   end

   always @(negedge clk) begin
      if (!reset && key_valid) pulses++;
      if (key_valid && kv_prev) long_pulses++;
      kv_prev = key_valid;
   end

   task automatic wait_valid(input int max, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (key_valid) seen = 1'b1;
      end
   endtask

   task automatic wait_col(input logic [3:0] v, input bit eq, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if ((col_n == v) == eq) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [3:0] exp_col;
      repeat (3) @(negedge clk);
      checks++;
      if ({key_code, digit_new, digit_old, key_valid} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outs: got %h %h %h %b expected 0 0 0 0",
                  key_code, digit_new, digit_old, key_valid);
      end
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         checks++;
         if (col_n !== exp_col) begin
            errors++;
            $display("FAIL scan_col[%0d]: got %b expected %b", k, col_n, exp_col);
         end
         checks++;
         if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid[%0d]: got %b expected 0", k, key_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_clean_press;
      int p0;
      bit seen;
      p0 = pulses;
      pressed[1*4+2] = 1'b1;
      wait_valid(60, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL press6_seen: got 0 expected 1");
      end
      checks++;
      if ({key_code, digit_new, digit_old} !== 12'h660) begin
         errors++;
         $display("FAIL press6_code: got %h%h%h expected 660",
                  key_code, digit_new, digit_old);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (col_n !== 4'b1011) begin
         errors++;
         $display("FAIL press6_frozen: got %b expected 1011", col_n);
      end
      checks++;
      if (pulses - p0 !== 1) begin
         errors++;
         $display("FAIL press6_pulses: got %0d expected 1", pulses - p0);
      end
      pressed = '0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_two_keys;
      int p0;
      bit seen;
      p0 = pulses;
      pressed[1*4+1] = 1'b1;
      wait_valid(60, seen);
      repeat (10) @(negedge clk);
      pressed = '0;
      repeat (40) @(negedge clk);
      pressed[0*4+3] = 1'b1;
      wait_valid(60, seen);
      repeat (10) @(negedge clk);
      pressed = '0;
      repeat (40) @(negedge clk);
      checks++;
      if ({key_code, digit_new, digit_old} !== 12'hAA5) begin
         errors++;
         $display("FAIL two_keys_digits: got %h%h%h expected AA5",
                  key_code, digit_new, digit_old);
      end
      checks++;
      if (pulses - p0 !== 2) begin
         errors++;
         $display("FAIL two_keys_pulses: got %0d expected 2", pulses - p0);
      end
   endtask

   task automatic test_bounce;
      int p0;
      logic [3:0] c0;
      p0 = pulses;
      force_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         force_rows = (i % 2 == 0) ? 4'b1011 : 4'b1111;
         repeat (4) @(negedge clk);
      end
      force_rows = 4'b1111;
      repeat (12) @(negedge clk);
      force_en = 1'b0;
      checks++;
      if (pulses - p0 !== 0) begin
         errors++;
         $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0);
      end
      c0 = col_n;
      repeat (4) @(negedge clk);
      checks++;
      if (col_n === c0) begin
         errors++;
         $display("FAIL bounce_resume: got %b expected change from %b", col_n, c0);
      end
      checks++;
      if ({digit_new, digit_old} !== 8'hA5) begin
         errors++;
         $display("FAIL bounce_digits: got %h%h expected A5", digit_new, digit_old);
      end
   endtask

   task automatic test_release_bounce;
      int p0;
      bit seen;
      p0 = pulses;
      pressed[0*4+2] = 1'b1;
      wait_valid(60, seen);
      checks++;
      if (!seen || key_code !== 4'h3) begin
         errors++;
         $display("FAIL rel_press3: got seen=%b code=%h expected 1 3", seen, key_code);
      end
      pressed = '0;
      repeat (4) @(negedge clk);
      pressed[0*4+2] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (pulses - p0 !== 1) begin
         errors++;
         $display("FAIL rel_bounce_pulses: got %0d expected 1", pulses - p0);
      end
      checks++;
      if (col_n !== 4'b1011) begin
         errors++;
         $display("FAIL rel_bounce_frozen: got %b expected 1011", col_n);
      end
      checks++;
      if ({digit_new, digit_old} !== 8'h3A) begin
         errors++;
         $display("FAIL rel_bounce_digits: got %h%h expected 3A", digit_new, digit_old);
      end
      pressed = '0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_reset_in_debounce;
      int p0;
      bit ok;
      p0 = pulses;
      pressed[2*4+2] = 1'b1;
      wait_col(4'b1011, 1'b0, ok);
      wait_col(4'b1011, 1'b1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_reach_col2: got %b expected 1011", col_n);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (pulses - p0 !== 0) begin
         errors++;
         $display("FAIL rst_early_pulse: got %0d expected 0", pulses - p0);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({col_n, key_code, digit_new, digit_old, key_valid} !== 17'b1110_0000_0000_0000_0) begin
         errors++;
         $display("FAIL rst_async: got col=%b %h %h %h %b expected 1110 0 0 0 0",
                  col_n, key_code, digit_new, digit_old, key_valid);
      end
      pressed = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (pulses - p0 !== 0 || digit_new !== 4'h0) begin
         errors++;
         $display("FAIL rst_after: got pulses=%0d new=%h expected 0 0",
                  pulses - p0, digit_new);
      end
   endtask

   task automatic test_two_rows;
      int p0;
      bit ok;
      p0 = pulses;
      pressed[1*4+0] = 1'b1;
      pressed[2*4+0] = 1'b1;
      wait_col(4'b1110, 1'b0, ok);
      wait_col(4'b1110, 1'b1, ok);
      repeat (4) @(negedge clk);
      checks++;
      if (col_n !== 4'b1101) begin
         errors++;
         $display("FAIL two_rows_advance: got %b expected 1101", col_n);
      end
      repeat (32) @(negedge clk);
      checks++;
      if (pulses - p0 !== 0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL two_rows_event: got pulses=%0d code=%h expected 0 0",
                  pulses - p0, key_code);
      end
      pressed = '0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_pulse_width;
      checks++;
      if (long_pulses !== 0) begin
         errors++;
         $display("FAIL pulse_width: got %0d long pulses expected 0", long_pulses);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_two_keys();
      test_bounce();
      test_release_bounce();
      test_reset_in_debounce();
      test_two_rows();
      test_pulse_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad and turns each debounced press into one hex key event. It is the input-side counterpart of the multiplexed seven-segment display path. The block time-multiplexes the keypad columns the way the display multiplexes its anodes, synchronizes and debounces the row returns, and emits a single-cycle `key_valid` strobe with the key code. It also keeps the last two keys entered as `digit_new` and `digit_old`, which drive the two-digit display directly.

## Interface
- `SCAN_DIV_EXP`, default 14: each column is driven for 2^N clk cycles. At 24 MHz this is about 0.68 ms per column.
- `DEBOUNCE_TICKS`, default 30: number of consecutive scan ticks a press or release must be stable, about 20 ms.
- `clk` input 1: system clock, 24 MHz HSOSC.
- `reset` input 1: reset, asynchronous, active-high.
- `row_n` input 4: keypad rows, active-low, external pull-ups, asynchronous to clk.
- `col_n` output 4: column drive, active-low, exactly one bit low at all times.
- `key_code` output 4: hex value of the last accepted key.
- `key_valid` output 1: one-cycle strobe on each accepted press.
- `digit_new` output 4: most recent key.
- `digit_old` output 4: key accepted before `digit_new`.

## Operation
- Reset values:
  - `col_n` = 4'b1110 (column 0).
  - `key_code`, `digit_new`, `digit_old` = 0.
  - `key_valid` = 0.
  - State SCAN, all counters 0.
  - Synchronizer flops = 4'b1111.
- `row_n` passes through a 2-flop synchronizer to give `rows_s`. All decisions use `rows_s` only.
- Divider:
  - Free-running N-bit counter.
  - `tick` is high when the counter equals all-ones, so one tick per 2^N cycles.
  - Rows are sampled only on `tick`.
- Key map, `[row][col]`:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- States:
  - SCAN: on `tick`, if exactly one `rows_s` bit is low, latch that row index and the current column, clear the debounce count, and go to DEBOUNCE. The column stays frozen. Otherwise, including zero rows or two or more rows low, advance the column (3 wraps to 0).
  - DEBOUNCE: on `tick`, if only the latched row is low, increment the count. When the count reaches `DEBOUNCE_TICKS`, go to HELD, pulse `key_valid`, set `key_code` = map, shift `digit_old` <= `digit_new`, and set `digit_new` <= map. Any other row pattern returns to SCAN, advances the column, and emits no event.
  - HELD: column frozen. On `tick`, if the latched row is high, clear the count and go to RELEASE. Other rows are ignored. There is no auto-repeat.
  - RELEASE: on `tick`, if the latched row is high, increment the count, and at `DEBOUNCE_TICKS` go to SCAN and advance the column. If the latched row is low, return to HELD with the count cleared and no new event.
- Boundary cases:
  - A second key pressed while a key is HELD is never reported, even after the first key is released, unless it is still held when SCAN reaches its column.
  - Bounce during DEBOUNCE aborts without an event.
  - Asynchronous reset mid-operation returns everything to reset values at once. No `key_valid` is produced by reset.
- Width rule: the debounce counter is `$clog2(DEBOUNCE_TICKS+1)` bits and saturates; it never wraps.

## Timing
- All outputs are registered and change only on posedge clk, except under asynchronous reset.
- Synchronizer latency is 2 cycles. `row_n` must be stable 2 cycles before a tick to be seen.
- Press latency: `key_valid` is high in the cycle after the tick on which the count reaches `DEBOUNCE_TICKS`. That is `DEBOUNCE_TICKS` ticks after the detecting tick. `key_valid` lasts exactly 1 cycle.
- `key_code`, `digit_new` and `digit_old` update in the same cycle that `key_valid` rises, and hold until the next event.
- Column change: `col_n` updates in the cycle after a tick, so each column dwells exactly 2^N cycles during SCAN.
- Minimum gap between events for one key: `DEBOUNCE_TICKS` release ticks plus one SCAN sweep to its column plus `DEBOUNCE_TICKS`.

## Structure
- Package `keypad_pkg`:
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t`.
  - `function keymap(row, col)` returning logic [3:0].
- Sub-module `row_sync`: parameterized-width 2-flop synchronizer with asynchronous reset to all-ones.
- Top-level integration: `digit_new` and `digit_old` replace the switch-driven digit registers feeding the display muxer.

## Test plan
All scenarios use `SCAN_DIV_EXP`=2 and `DEBOUNCE_TICKS`=3.
- Reset, no keys: `col_n` cycles 1110, 1101, 1011, 0111, 1110, with 4 cycles per value. `key_valid` never asserts.
- Clean press of row1/col2, held 40 cycles: exactly one `key_valid` pulse, `key_code`=6, `digit_new`=6, `digit_old`=0, column frozen at 1011 while held.
- Two keys in sequence: press "5" then "A", each cleanly pressed and released. Result is `digit_new`=A, `digit_old`=5, with 2 `key_valid` pulses total.
- Bounce: the row toggles low and high every tick for 6 ticks, then goes high. No `key_valid`, and scanning resumes.
- Release bounce in HELD: high for 1 tick, low, then held. No second pulse.
- Async reset asserted during DEBOUNCE of key "9": all outputs return to 0, `col_n`=1110, no pulse after reset is released.
- Two rows low in the same column at the detecting tick: ignored, column advances.
